// File: rtl/pwm_pkg.sv
// Shared definitions for the three-channel PWM generator and the
// configuration bus layout it shares with the SPI memory manager.
package pwm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_CH = 3;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Element k of duty_cycle holds duty_cycle_(k+1).
  typedef struct packed {
    word_t                    counter_value;
    word_t                    prescaler;
    word_t [NUM_CH-1:0]       duty_cycle;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed duty threshold, comparator against the shared
// period counter, and the registered output.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic  i_Clk,
  input  logic  i_Rst,
  input  logic  load,
  input  logic  run,
  input  word_t per_cnt,
  input  word_t duty_in,
  output logic  pwm
);

  word_t duty_q, duty_d;
  logic  pwm_q, pwm_d;

  // Compare uses the shadow as it stands this cycle; a load lands next cycle.
  always_comb begin
    duty_d = load ? duty_in : duty_q;
    pwm_d  = run && (per_cnt < duty_q);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_core.sv
// Three-channel PWM generator: prescaler, shared period counter and
// IDLE/RUN control, with configuration shadowed at period boundaries.
module pwm_core
  import pwm_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [DATA_W-1:0] counter_value,
  input  logic [DATA_W-1:0] prescaler,
  input  logic [DATA_W-1:0] duty_cycle_1,
  input  logic [DATA_W-1:0] duty_cycle_2,
  input  logic [DATA_W-1:0] duty_cycle_3,
  input  logic              enable_pwm,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              running
);

  pwm_cfg_t cfg;
  state_e   state_q, state_d;
  word_t    pre_cnt_q, pre_cnt_d;
  word_t    per_cnt_q, per_cnt_d;
  word_t    sh_pre_q, sh_pre_d;
  word_t    sh_per_q, sh_per_d;
  logic     period_start_q, period_start_d;
  logic     running_q, running_d;
  logic     load, run, tick;

  always_comb begin
    cfg.counter_value = counter_value;
    cfg.prescaler     = prescaler;
    cfg.duty_cycle[0] = duty_cycle_1;
    cfg.duty_cycle[1] = duty_cycle_2;
    cfg.duty_cycle[2] = duty_cycle_3;
  end

  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    per_cnt_d      = per_cnt_q;
    period_start_d = 1'b0;
    running_d      = running_q;
    load           = 1'b0;
    run            = 1'b0;
    tick           = (pre_cnt_q == sh_pre_q);

    case (state_q)
      IDLE: begin
        pre_cnt_d = '0;
        per_cnt_d = '0;
        running_d = enable_pwm;
        if (enable_pwm) begin
          load           = 1'b1;
          period_start_d = 1'b1;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (!enable_pwm) begin
          state_d   = IDLE;
          pre_cnt_d = '0;
          per_cnt_d = '0;
          running_d = 1'b0;
        end else begin
          run       = 1'b1;
          running_d = 1'b1;
          pre_cnt_d = tick ? '0 : pre_cnt_q + word_t'(1);
          // Equality test before increment keeps both counters from wrapping.
          if (tick) begin
            if (per_cnt_q == sh_per_q) begin
              per_cnt_d      = '0;
              load           = 1'b1;
              period_start_d = 1'b1;
            end else begin
              per_cnt_d = per_cnt_q + word_t'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    sh_pre_d = load ? cfg.prescaler     : sh_pre_q;
    sh_per_d = load ? cfg.counter_value : sh_per_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q        <= IDLE;
      pre_cnt_q      <= '0;
      per_cnt_q      <= '0;
      sh_pre_q       <= '0;
      sh_per_q       <= '0;
      period_start_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      per_cnt_q      <= per_cnt_d;
      sh_pre_q       <= sh_pre_d;
      sh_per_q       <= sh_per_d;
      period_start_q <= period_start_d;
      running_q      <= running_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_channel u_ch (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .load    (load),
      .run     (run),
      .per_cnt (per_cnt_q),
      .duty_in (cfg.duty_cycle[k]),
      .pwm     (pwm_out[k])
    );
  end

  assign period_start = period_start_q;
  assign running      = running_q;

endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: period-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pwm_core;
  import pwm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  word_t       cv, pre, d1, d2, d3;
  logic        en;
  logic [2:0]  pwm;
  logic        ps, run;

  always #5 clk = ~clk;

  pwm_core dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .counter_value (cv),
    .prescaler     (pre),
    .duty_cycle_1  (d1),
    .duty_cycle_2  (d2),
    .duty_cycle_3  (d3),
    .enable_pwm    (en),
    .pwm_out       (pwm),
    .period_start  (ps),
    .running       (run)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference: position j (clocks since the last shadow load) inside a period of
  // P=(pre+1)*(per+1) clocks; channel k is high while j-1 < (pre+1)*min(duty,per+1).
  bit              m_run = 1'b0;
  longint unsigned m_j = 0, m_P = 1;
  longint unsigned m_H [3];
  logic [2:0]      e_pwm = '0;
  logic            e_ps  = 1'b0;
  logic            e_run = 1'b0;

  function automatic longint unsigned hi_time(word_t p, word_t c, word_t d);
    longint unsigned w = longint'(c) + 1;
    longint unsigned dd = longint'(d);
    return (longint'(p) + 1) * ((dd < w) ? dd : w);
  endfunction

  function automatic void m_load();
    m_P    = (longint'(pre) + 1) * (longint'(cv) + 1);
    m_H[0] = hi_time(pre, cv, d1);
    m_H[1] = hi_time(pre, cv, d2);
    m_H[2] = hi_time(pre, cv, d3);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_j = 0; e_pwm = '0; e_ps = 1'b0; e_run = 1'b0;
    end else if (!m_run) begin
      e_pwm = '0;
      e_ps  = 1'b0;
      if (en) begin
        m_load(); m_run = 1'b1; m_j = 0; e_ps = 1'b1; e_run = 1'b1;
      end
    end else if (!en) begin
      m_run = 1'b0; e_pwm = '0; e_ps = 1'b0; e_run = 1'b0;
    end else begin
      m_j++;
      for (int k = 0; k < 3; k++) e_pwm[k] = ((m_j - 1) < m_H[k]);
      e_ps = 1'b0;
      if (m_j == m_P) begin
        m_load(); m_j = 0; e_ps = 1'b1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst) chk("cycle_model", {run, ps, pwm}, {e_run, e_ps, e_pwm});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t rdc();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FFFF;
    if (r == 1) return '0;
    return word_t'($urandom_range(0, 9));
  endfunction

  logic [7:0]  v0, vps;
  logic [11:0] v12;
  logic        v1, v2;
  int          c;

  initial begin
    en = 1'b0; cv = '0; pre = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (3) tick();
    chk("reset_state", {run, ps, pwm}, 5'b00000);
    rst = 1'b0;
    tick();
    chk("idle_state", {run, ps, pwm}, 5'b00000);

    // pre=0, per=3, duty 2/0/4
    pre = 0; cv = 3; d1 = 2; d2 = 0; d3 = 4; en = 1'b1;
    tick();
    chk("s1_enable", {run, ps, pwm}, 5'b11000);
    v1 = 1'b0; v2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      v0[7-i] = pwm[0]; vps[7-i] = ps; v1 |= pwm[1]; v2 &= pwm[2];
    end
    chk("s1_ch1_pattern", v0, 8'b11001100);
    chk("s1_period_start", vps, 8'b00010001);
    chk("s1_ch2_low", v1, 1'b0);
    chk("s1_ch3_high", v2, 1'b1);

    // pre=2, per=1, duty_1=1: 6-clock period, 3 high
    en = 1'b0; tick();
    pre = 2; cv = 1; d1 = 1; en = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      v12[11-i] = pwm[0];
    end
    chk("s2_pattern", v12, 12'b111000111000);

    // mid-period duty update takes effect only after the wrap
    en = 1'b0; tick();
    pre = 0; cv = 9; d1 = 5; en = 1'b1;
    tick();
    c = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      c += int'(pwm[0]);
      if (i == 3) d1 = 8;
      if (i == 10) chk("s3_wrap_ps", ps, 1'b1);
    end
    chk("s3_old_high", c, 5);
    c = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      c += int'(pwm[0]);
    end
    chk("s3_new_high", c, 8);

    // stop mid-high, then restart
    tick(); tick();
    chk("s4_high", pwm[0], 1'b1);
    en = 1'b0;
    tick();
    chk("s4_stop", {run, ps, pwm}, 5'b00000);
    en = 1'b1;
    tick();
    chk("s4_restart", {run, ps, pwm}, 5'b11000);
    tick();
    chk("s4_first", {ps, pwm}, 4'b0101);

    // asynchronous reset between edges
    tick(); tick();
    #3 rst = 1'b1;
    #1 chk("s5_async_rst", {run, ps, pwm}, 5'b00000);
    #2 rst = 1'b0;
    tick();
    chk("s5_reenter", {run, ps, pwm}, 5'b11000);

    // one-tick period, duty 1/0/max
    en = 1'b0; tick();
    cv = 0; pre = 0; d1 = 1; d2 = 0; d3 = 32'hFFFF_FFFF; en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_steady", {ps, pwm}, 4'b1101);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (en ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 30)) en = ~en;
      if ($urandom_range(0, 9) == 0) begin
        pre = word_t'($urandom_range(0, 3));
        cv  = word_t'($urandom_range(0, 7));
        d1  = rdc(); d2 = rdc(); d3 = rdc();
      end
      if (i == 1500) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
